// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, iterative restoring divider, data SRAM request
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 140,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic                       es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] bus_r;
  div_state_t                 state, state_nxt;

  logic [3:0]  op;
  logic        res_from_mem, mem_we, gr_we;
  logic [4:0]  dest;
  logic [31:0] src1, src2, rkd_value, pc;

  assign op           = bus_r[139:136];
  assign res_from_mem = bus_r[135];
  assign mem_we       = bus_r[134];
  assign gr_we        = bus_r[133];
  assign dest         = bus_r[132:128];
  assign src1         = bus_r[127:96];
  assign src2         = bus_r[95:64];
  assign rkd_value    = bus_r[63:32];
  assign pc           = bus_r[31:0];

  logic is_div, signed_op, es_ready_go;
  assign is_div      = op[3] & op[2];
  assign signed_op   = ~op[0];
  assign es_ready_go = !is_div || (state == DONE);
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) bus_r <= ds_to_es_bus;
    end
  end

  // Divider: div_q starts as the dividend and shifts quotient bits in from the right.
  logic [31:0] div_q, div_r, div_d;
  logic [4:0]  div_cnt;
  logic        q_neg, r_neg;
  logic [32:0] step_tmp, step_diff;
  logic        step_ge;

  assign step_tmp  = {div_r, div_q[31]};
  assign step_diff = step_tmp - {1'b0, div_d};
  assign step_ge   = ~step_diff[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (es_valid && is_div) state_nxt = BUSY;
      BUSY: if (div_cnt == 5'd31) state_nxt = DONE;
      DONE: if (ms_allowin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      div_r   <= '0;
      div_d   <= '0;
      div_cnt <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (state == IDLE && es_valid && is_div) begin
      div_q   <= (signed_op && src1[31]) ? -src1 : src1;
      div_d   <= (signed_op && src2[31]) ? -src2 : src2;
      div_r   <= '0;
      div_cnt <= '0;
      q_neg   <= src1[31] ^ src2[31];
      r_neg   <= src1[31];
    end else if (state == BUSY) begin
      div_r   <= step_ge ? step_diff[31:0] : step_tmp[31:0];
      div_q   <= {div_q[30:0], step_ge};
      div_cnt <= div_cnt + 5'd1;
    end
  end

  logic [31:0] quot, rem, div_res;
  always_comb begin
    quot = (signed_op && q_neg) ? -div_q : div_q;
    rem  = (signed_op && r_neg) ? -div_r : div_r;
    if (src2 == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = src1;
    end else if (src1 == 32'h8000_0000 && src2 == 32'hFFFF_FFFF) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
    div_res = op[1] ? rem : quot;
  end

  logic [31:0] alu_result;
  always_comb begin
    alu_result = '0;
    case (op)
      4'd0:  alu_result = src1 + src2;
      4'd1:  alu_result = src1 - src2;
      4'd2:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      4'd3:  alu_result = {31'd0, src1 < src2};
      4'd4:  alu_result = src1 & src2;
      4'd5:  alu_result = src1 | src2;
      4'd6:  alu_result = ~(src1 | src2);
      4'd7:  alu_result = src1 ^ src2;
      4'd8:  alu_result = src1 << src2[4:0];
      4'd9:  alu_result = src1 >> src2[4:0];
      4'd10: alu_result = $signed(src1) >>> src2[4:0];
      4'd11: alu_result = src2;
      default: alu_result = div_res;
    endcase
  end

  // Request only on the handoff cycle so a stalled store is issued exactly once.
  assign data_sram_en    = es_valid && es_ready_go && ms_allowin && (res_from_mem || mem_we);
  assign data_sram_we    = {4{data_sram_en && mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, alu_result, pc};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed and randomized bench for exe_stage
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [139:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int compared = 0;
  int mismatched = 0;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] mk(input logic [3:0] op, input logic rfm, input logic mwe,
                                      input logic gwe, input logic [4:0] dest, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] rkd, input logic [31:0] pc);
    return {op, rfm, mwe, gwe, dest, s1, s2, rkd, pc};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [4:0] sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    if (op >= 4'd12) begin
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    end
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return sa >>> sh;
      4'd11: return b;
      4'd12: return sa / sb;
      4'd13: return a / b;
      4'd14: return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // One instruction in flight with ms_allowin=1: latency, allowin-during-divide and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dest, input logic [31:0] pc, input logic [31:0] exp,
                        input string tag);
    int lat;
    logic saw_allow;
    int exp_lat;
    exp_lat = (op >= 4'd12) ? 34 : 1;
    @(negedge clk);
    ds_to_es_bus = mk(op, 1'b0, 1'b0, 1'b1, dest, a, b, 32'd0, pc);
    ds_to_es_valid = 1'b1;
    ms_allowin = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    lat = 1;
    saw_allow = 1'b0;
    while (!es_to_ms_valid && lat < 100) begin
      if (es_allowin) saw_allow = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 71'(lat), 71'(exp_lat));
    check({tag, "_bus"}, es_to_ms_bus, {1'b0, 1'b1, dest, exp, pc});
    if (op >= 4'd12) check({tag, "_allowin_busy"}, 71'(saw_allow), 71'(0));
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int lat;

    reset = 1'b1;
    ms_allowin = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Park an instruction in the stage, then reset between edges
    @(negedge clk);
    ds_to_es_bus = mk(4'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd1, 32'd2, 32'd0, 32'h40);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    check("pre_reset_valid", 71'(es_to_ms_valid), 71'(1));
    #2 reset = 1'b1;
    #1;
    check("rst_allowin", 71'(es_allowin), 71'(1));
    check("rst_valid", 71'(es_to_ms_valid), 71'(0));
    check("rst_en", 71'(data_sram_en), 71'(0));
    check("rst_we", 71'(data_sram_we), 71'(0));
    check("rst_bus", es_to_ms_bus, 71'(0));
    @(negedge clk);
    reset = 1'b0;

    run_op(4'd0,  32'd5,         32'd7,         5'd3, 32'h1000, 32'd12,         "add");
    run_op(4'd10, 32'h8000_0000, 32'd4,         5'd4, 32'h1004, 32'hF800_0000,  "sra");
    run_op(4'd3,  32'd1,         32'hFFFF_FFFF, 5'd5, 32'h1008, 32'd1,          "sltu");
    run_op(4'd2,  32'd1,         32'hFFFF_FFFF, 5'd6, 32'h100C, 32'd0,          "slt");
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'h1010, 32'hFFFF_FFFD,  "div");
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'h1014, 32'hFFFF_FFFF,  "mod");
    run_op(4'd13, 32'hFFFF_FFFF, 32'd0,         5'd9, 32'h1018, 32'hFFFF_FFFF,  "divu_z");
    run_op(4'd15, 32'd9,         32'd0,         5'd10, 32'h101C, 32'd9,         "modu_z");
    run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h1020, 32'h8000_0000, "div_ovf");
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h1024, 32'd0,         "mod_ovf");

    // Store stalled by memory stage for 3 cycles
    @(negedge clk);
    ds_to_es_bus = mk(4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'd4, 32'hDEAD_BEEF, 32'h2000);
    ds_to_es_valid = 1'b1;
    ms_allowin = 1'b0;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("st_stall_en", 71'(data_sram_en), 71'(0));
      check("st_stall_valid", 71'(es_to_ms_valid), 71'(1));
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    check("st_en", 71'(data_sram_en), 71'(1));
    check("st_we", 71'(data_sram_we), 71'(4'hF));
    check("st_addr", 71'(data_sram_addr), 71'(32'h104));
    check("st_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
    @(negedge clk);
    check("st_en_after", 71'(data_sram_en), 71'(0));

    // Reset during BUSY step 10 of a divide
    ds_to_es_bus = mk(4'd12, 1'b0, 1'b0, 1'b1, 5'd1, 32'd100, 32'd7, 32'd0, 32'h3000);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    repeat (11) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_allowin", 71'(es_allowin), 71'(1));
    check("mid_rst_valid", 71'(es_to_ms_valid), 71'(0));
    check("mid_rst_bus", es_to_ms_bus, 71'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd12, 32'd100, 32'd7, 5'd2, 32'h3004, 32'd14, "div_after_rst");

    // Back-to-back ADD, DIV, ADD
    @(negedge clk);
    ds_to_es_bus = mk(4'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'd2, 32'd0, 32'h40A0);
    ds_to_es_valid = 1'b1;
    ms_allowin = 1'b1;
    @(negedge clk);
    check("b2b_add1", es_to_ms_bus, {2'b01, 5'd1, 32'd3, 32'h40A0});
    ds_to_es_bus = mk(4'd12, 1'b0, 1'b0, 1'b1, 5'd2, 32'd100, 32'd7, 32'd0, 32'h40A4);
    @(negedge clk);
    ds_to_es_bus = mk(4'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd10, 32'd20, 32'd0, 32'h40A8);
    check("b2b_div_allowin", 71'(es_allowin), 71'(0));
    lat = 1;
    while (!es_to_ms_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_div_lat", 71'(lat), 71'(34));
    check("b2b_div", es_to_ms_bus, {2'b01, 5'd2, 32'd14, 32'h40A4});
    check("b2b_handoff_allowin", 71'(es_allowin), 71'(1));
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    check("b2b_add2_valid", 71'(es_to_ms_valid), 71'(1));
    check("b2b_add2", es_to_ms_bus, {2'b01, 5'd3, 32'd30, 32'h40A8});
    @(negedge clk);
    check("b2b_empty", 71'(es_to_ms_valid), 71'(0));

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50)) - 32'd25;
      if (rop >= 4'd12 && $urandom_range(0, 2) == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), $urandom, ref_alu(rop, ra, rb), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
